axil_sram_bridge: RTL and testbench
===================================

Name: axil_sram_bridge

Overview:
AXI4-Lite slave front-end placed directly upstream of the core's SRAM/pmem model. It accepts AR/R/AW/W/B channel traffic from the IFU/LSU arbiter and converts each transaction into a single-cycle ren or wen request on the memory side. It then captures the memory's one-cycle rvalid/bvalid pulse and holds it as a proper AXI response until the master accepts it. It serialises reads and writes, alternates priority between them, and times out on an unresponsive slave.

Parameters:
ADDR_WIDTH, 32, address width on both sides
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
TIMEOUT, 255, max cycles spent waiting for a memory response before SLVERR; 1..255

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
s_araddr  in  ADDR_WIDTH  AXI read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  DATA_WIDTH  read data
s_rresp  out  2  read response
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
s_awaddr  in  ADDR_WIDTH  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  DATA_WIDTH  write data
s_wstrb  in  DATA_WIDTH/8  byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
m_araddr  out  ADDR_WIDTH  memory read address
m_ren  out  1  memory read request, one-cycle pulse
m_rdata  in  DATA_WIDTH  memory read data
m_rresp  in  2  memory read response
m_rvalid  in  1  memory read data valid (one-cycle pulse)
m_awaddr  out  ADDR_WIDTH  memory write address
m_wdata  out  DATA_WIDTH  memory write data
m_wstrb  out  DATA_WIDTH/8  memory write strobes
m_wen  out  1  memory write request, one-cycle pulse
m_bresp  in  2  memory write response
m_bvalid  in  1  memory write done (one-cycle pulse)

Behaviour:
- FSM states: IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_REQ, WR_WAIT, WR_RESP.
- Reset: state=IDLE; aw_full=w_full=0; prio_read=0; timeout counter=0.
  - All outputs are 0: s_rdata, s_rresp, s_rvalid, s_bresp, s_bvalid, m_ren, m_wen, m_araddr, m_awaddr, m_wdata, m_wstrb.
  - s_arready/s_awready/s_wready take their combinational values from the reset state, so all three are 1.
- Reset mid-transaction drops the transaction. No response is issued, and m_ren/m_wen fall to 0 asynchronously.
- Write buffers:
  - s_awready = !aw_full; s_wready = !w_full.
  - Each handshake latches its address, or its data and strobe, and sets the matching full flag.
  - AW and W are independent and may arrive in any order or in the same cycle.
  - Both flags clear on the IDLE->WR_REQ transition.
- Arbitration (IDLE only): wr_ok = aw_full & w_full.
  - s_arready = (state==IDLE) & (!wr_ok | prio_read).
  - If an AR handshake occurs: latch s_araddr into m_araddr, go to RD_REQ.
  - Else if wr_ok: go to WR_REQ.
  - When both are pending, prio_read decides. prio_read is set when a write completes its B handshake and cleared when a read completes its R handshake, giving strict alternation.
- m_ren = (state==RD_REQ) and m_wen = (state==WR_REQ). Each is exactly one cycle; the two are never asserted together.
- RD_REQ -> RD_WAIT unconditionally, counter cleared. WR_REQ -> WR_WAIT likewise.
- WAIT states:
  - m_rvalid/m_bvalid high: capture m_rdata/m_rresp (or m_bresp), go to RESP.
  - Otherwise the counter increments. On reaching TIMEOUT, go to RESP with resp=2'b10 (SLVERR) and s_rdata=0.
  - A response pulse that arrives after a timeout is ignored.
- RD_RESP: s_rvalid=1. s_rdata/s_rresp stay stable until s_rready, then s_rvalid=0 and state returns to IDLE.
- WR_RESP: s_bvalid=1 with s_bresp stable until s_bready, then IDLE.
- Latency with a 1-cycle memory:
  - Read: AR handshake in cycle 0 -> m_ren in cycle 1 -> m_rvalid in cycle 2 -> s_rvalid in cycle 3.
  - Write: second of AW/W handshakes in cycle k -> m_wen in cycle k+2 -> s_bvalid in cycle k+4.
- Only one memory transaction is in flight at a time. The next AW/W may be buffered while a read or write is in progress.
- wstrb=0 is still issued as a write and receives a normal B response.

Test Plan:
- Reset release, read 0x80000000 with memory returning 0xDEADBEEF, rready=1 -> m_ren pulse in cycle 1 only; s_rvalid in cycle 3 with s_rdata=0xDEADBEEF, rresp=0; s_arready low in cycles 1-3.
- W (0x12345678, strb 4'b0011) two cycles before AW (0x80000010) -> exactly one m_wen pulse with addr 0x80000010, data 0x12345678, strb 0011; bvalid held for 3 cycles while bready=0, bresp=0.
- AR and complete AW+W pending in IDLE after reset -> write issued first; next time both are pending, read issued first; alternation continues over 4 transactions.
- Memory model never asserts m_rvalid, TIMEOUT=8 -> s_rvalid in RD_RESP after 8 WAIT cycles with rresp=2'b10, rdata=0; a late m_rvalid in the next cycle is ignored.
- Assert rst while in WR_WAIT -> all outputs 0 immediately, no s_bvalid; next read after release completes normally.
- rready held low for 5 cycles while s_rvalid is high, with m_rdata toggling -> s_rdata stays constant; no new m_ren until the R handshake.

Source files
------------

// File: rtl/axil_sram_bridge_if.sv
// AXI4-Lite slave channels plus the single-cycle SRAM request/response bus
// that axil_sram_bridge sits between.
interface axil_sram_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] s_araddr;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rvalid;
  logic                  s_rready;
  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic                  s_awvalid;
  logic                  s_awready;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic [STRB_WIDTH-1:0] s_wstrb;
  logic                  s_wvalid;
  logic                  s_wready;
  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  s_bready;

  logic [ADDR_WIDTH-1:0] m_araddr;
  logic                  m_ren;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rvalid;
  logic [ADDR_WIDTH-1:0] m_awaddr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [STRB_WIDTH-1:0] m_wstrb;
  logic                  m_wen;
  logic [1:0]            m_bresp;
  logic                  m_bvalid;

  // Bridge view: AXI slave on the s_ side, memory requester on the m_ side.
  modport slave (
    input  s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid,
    input  s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid,
    output m_araddr, m_ren, m_awaddr, m_wdata, m_wstrb, m_wen,
    input  m_rdata, m_rresp, m_rvalid, m_bresp, m_bvalid
  );

  // Environment view: AXI master plus the memory model.
  modport master (
    output s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid,
    output s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid,
    input  m_araddr, m_ren, m_awaddr, m_wdata, m_wstrb, m_wen,
    output m_rdata, m_rresp, m_rvalid, m_bresp, m_bvalid
  );
endinterface

// File: rtl/axil_sram_bridge.sv
// AXI4-Lite slave to single-cycle SRAM bridge: one memory access in flight,
// read/write alternation when both pend, and a response timeout.
module axil_sram_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic               clk,
  input logic               rst,
  axil_sram_bridge_if.slave bus
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdWait, StRdResp, StWrReq, StWrWait, StWrResp
  } state_e;

  state_e                state_q, state_d;
  logic                  aw_full_q, aw_full_d;
  logic                  w_full_q, w_full_d;
  logic                  prio_read_q, prio_read_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] araddr_q, awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [1:0]            bresp_q, bresp_d;

  logic       wr_ok, arready, ar_hs, aw_hs, w_hs;
  logic [7:0] cnt_inc;

  assign wr_ok   = aw_full_q & w_full_q;
  assign arready = (state_q == StIdle) & (~wr_ok | prio_read_q);
  assign ar_hs   = bus.s_arvalid & arready;
  assign aw_hs   = bus.s_awvalid & ~aw_full_q;
  assign w_hs    = bus.s_wvalid & ~w_full_q;
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    aw_full_d   = aw_full_q | aw_hs;
    w_full_d    = w_full_q | w_hs;
    prio_read_d = prio_read_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    bresp_d     = bresp_q;
    unique case (state_q)
      StIdle: begin
        if (ar_hs) begin
          state_d = StRdReq;
        end else if (wr_ok) begin
          state_d   = StWrReq;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
        end
      end
      StRdReq: begin
        state_d = StRdWait;
        cnt_d   = 8'd0;
      end
      StRdWait: begin
        if (bus.m_rvalid) begin
          rdata_d = bus.m_rdata;
          rresp_d = bus.m_rresp;
          state_d = StRdResp;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TimeoutCnt) begin
            rdata_d = '0;
            rresp_d = 2'b10;
            state_d = StRdResp;
          end
        end
      end
      StRdResp: begin
        if (bus.s_rready) begin
          state_d     = StIdle;
          prio_read_d = 1'b0;
        end
      end
      StWrReq: begin
        state_d = StWrWait;
        cnt_d   = 8'd0;
      end
      StWrWait: begin
        if (bus.m_bvalid) begin
          bresp_d = bus.m_bresp;
          state_d = StWrResp;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TimeoutCnt) begin
            bresp_d = 2'b10;
            state_d = StWrResp;
          end
        end
      end
      StWrResp: begin
        if (bus.s_bready) begin
          state_d     = StIdle;
          prio_read_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      aw_full_q   <= 1'b0;
      w_full_q    <= 1'b0;
      prio_read_q <= 1'b0;
      cnt_q       <= 8'd0;
      araddr_q    <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      rresp_q     <= 2'b00;
      bresp_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      aw_full_q   <= aw_full_d;
      w_full_q    <= w_full_d;
      prio_read_q <= prio_read_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      bresp_q     <= bresp_d;
      if (ar_hs) araddr_q <= bus.s_araddr;
      // A new AW/W may land during WR_REQ; m_wen has already sampled the old values.
      if (aw_hs) awaddr_q <= bus.s_awaddr;
      if (w_hs) begin
        wdata_q <= bus.s_wdata;
        wstrb_q <= bus.s_wstrb;
      end
    end
  end

  assign bus.s_arready = arready;
  assign bus.s_awready = ~aw_full_q;
  assign bus.s_wready  = ~w_full_q;
  assign bus.s_rdata   = rdata_q;
  assign bus.s_rresp   = rresp_q;
  assign bus.s_rvalid  = (state_q == StRdResp);
  assign bus.s_bresp   = bresp_q;
  assign bus.s_bvalid  = (state_q == StWrResp);
  assign bus.m_araddr  = araddr_q;
  assign bus.m_ren     = (state_q == StRdReq);
  assign bus.m_awaddr  = awaddr_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_wstrb   = wstrb_q;
  assign bus.m_wen     = (state_q == StWrReq);
endmodule

// File: tb/tb_axil_sram_bridge.sv
// Directed bench for axil_sram_bridge: latency, write buffering, arbitration
// alternation, timeout, async reset and response back-pressure.
module tb_axil_sram_bridge;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axil_sram_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_sram_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered in the RD_REQ cycle; leaves in IDLE after the R handshake.
  task automatic read_tail(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input int hold);
    bus.s_arvalid = 1'b0;
    chk("rd_ren", 64'(bus.m_ren), 64'd1);
    chk("rd_no_wen", 64'(bus.m_wen), 64'd0);
    chk("rd_addr", 64'(bus.m_araddr), 64'(addr));
    chk("rd_arready_req", 64'(bus.s_arready), 64'd0);
    tick();
    chk("rd_ren_once", 64'(bus.m_ren), 64'd0);
    chk("rd_arready_wait", 64'(bus.s_arready), 64'd0);
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = data;
    bus.m_rresp  = resp;
    tick();
    bus.m_rvalid = 1'b0;
    chk("rd_rvalid", 64'(bus.s_rvalid), 64'd1);
    chk("rd_rdata", 64'(bus.s_rdata), 64'(data));
    chk("rd_rresp", 64'(bus.s_rresp), 64'(resp));
    chk("rd_arready_resp", 64'(bus.s_arready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      bus.m_rdata = ~bus.m_rdata;
      tick();
      chk("rd_hold_rvalid", 64'(bus.s_rvalid), 64'd1);
      chk("rd_hold_rdata", 64'(bus.s_rdata), 64'(data));
      chk("rd_hold_no_ren", 64'(bus.m_ren), 64'd0);
    end
    bus.s_rready = 1'b1;
    tick();
    bus.s_rready = 1'b0;
    chk("rd_rvalid_drop", 64'(bus.s_rvalid), 64'd0);
  endtask

  // Entered in the WR_REQ cycle; leaves in IDLE after the B handshake.
  task automatic write_tail(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp, input int hold);
    chk("wr_wen", 64'(bus.m_wen), 64'd1);
    chk("wr_no_ren", 64'(bus.m_ren), 64'd0);
    chk("wr_addr", 64'(bus.m_awaddr), 64'(addr));
    chk("wr_data", 64'(bus.m_wdata), 64'(data));
    chk("wr_strb", 64'(bus.m_wstrb), 64'(strb));
    tick();
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    chk("wr_wen_once", 64'(bus.m_wen), 64'd0);
    bus.m_bvalid = 1'b1;
    bus.m_bresp  = resp;
    tick();
    bus.m_bvalid = 1'b0;
    chk("wr_bvalid", 64'(bus.s_bvalid), 64'd1);
    chk("wr_bresp", 64'(bus.s_bresp), 64'(resp));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("wr_hold_bvalid", 64'(bus.s_bvalid), 64'd1);
      chk("wr_hold_bresp", 64'(bus.s_bresp), 64'(resp));
      chk("wr_hold_no_wen", 64'(bus.m_wen), 64'd0);
    end
    bus.s_bready = 1'b1;
    tick();
    bus.s_bready = 1'b0;
    chk("wr_bvalid_drop", 64'(bus.s_bvalid), 64'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.s_araddr  = '0;
    bus.s_arvalid = 1'b0;
    bus.s_rready  = 1'b0;
    bus.s_awaddr  = '0;
    bus.s_awvalid = 1'b0;
    bus.s_wdata   = '0;
    bus.s_wstrb   = '0;
    bus.s_wvalid  = 1'b0;
    bus.s_bready  = 1'b0;
    bus.m_rdata   = '0;
    bus.m_rresp   = 2'b00;
    bus.m_rvalid  = 1'b0;
    bus.m_bresp   = 2'b00;
    bus.m_bvalid  = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_arready", 64'(bus.s_arready), 64'd1);
    chk("rst_awready", 64'(bus.s_awready), 64'd1);
    chk("rst_wready", 64'(bus.s_wready), 64'd1);
    chk("rst_rvalid", 64'(bus.s_rvalid), 64'd0);
    chk("rst_bvalid", 64'(bus.s_bvalid), 64'd0);
    chk("rst_ren", 64'(bus.m_ren), 64'd0);
    chk("rst_wen", 64'(bus.m_wen), 64'd0);
    chk("rst_rdata", 64'(bus.s_rdata), 64'd0);
    chk("rst_araddr", 64'(bus.m_araddr), 64'd0);
    rst = 1'b0;

    // Basic read: ren cycle 1, rvalid cycle 3
    bus.s_arvalid = 1'b1;
    bus.s_araddr  = 32'h8000_0000;
    chk("t1_arready", 64'(bus.s_arready), 64'd1);
    chk("t1_no_ren_c0", 64'(bus.m_ren), 64'd0);
    tick();
    read_tail(32'h8000_0000, 32'hDEAD_BEEF, 2'b00, 0);
    chk("t1_arready_back", 64'(bus.s_arready), 64'd1);

    // W two cycles ahead of AW
    bus.s_wvalid = 1'b1;
    bus.s_wdata  = 32'h1234_5678;
    bus.s_wstrb  = 4'b0011;
    chk("t2_wready", 64'(bus.s_wready), 64'd1);
    tick();
    bus.s_wvalid = 1'b0;
    chk("t2_wready_full", 64'(bus.s_wready), 64'd0);
    chk("t2_no_wen_early", 64'(bus.m_wen), 64'd0);
    tick();
    bus.s_awvalid = 1'b1;
    bus.s_awaddr  = 32'h8000_0010;
    chk("t2_awready", 64'(bus.s_awready), 64'd1);
    tick();
    bus.s_awvalid = 1'b0;
    chk("t2_no_wen_k1", 64'(bus.m_wen), 64'd0);
    chk("t2_awready_full", 64'(bus.s_awready), 64'd0);
    tick();
    write_tail(32'h8000_0010, 32'h1234_5678, 4'b0011, 2'b00, 3);
    chk("t2_no_second_wen", 64'(bus.m_wen), 64'd0);
    tick();
    chk("t2_no_second_wen2", 64'(bus.m_wen), 64'd0);

    // Alternation: W, R, W, R from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.s_awvalid = 1'b1;
    bus.s_awaddr  = 32'h8000_0040;
    bus.s_wvalid  = 1'b1;
    bus.s_wdata   = 32'h1111_1111;
    bus.s_wstrb   = 4'hF;
    tick();
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_arvalid = 1'b1;
    bus.s_araddr  = 32'h8000_0080;
    chk("t3_write_first", 64'(bus.s_arready), 64'd0);
    tick();
    bus.s_awvalid = 1'b1;
    bus.s_awaddr  = 32'h8000_0044;
    bus.s_wvalid  = 1'b1;
    bus.s_wdata   = 32'h2222_2222;
    bus.s_wstrb   = 4'hC;
    write_tail(32'h8000_0040, 32'h1111_1111, 4'hF, 2'b00, 0);
    chk("t3_read_second", 64'(bus.s_arready), 64'd1);
    tick();
    read_tail(32'h8000_0080, 32'hA1A1_A1A1, 2'b11, 0);
    bus.s_arvalid = 1'b1;
    bus.s_araddr  = 32'h8000_0084;
    chk("t3_write_third", 64'(bus.s_arready), 64'd0);
    tick();
    write_tail(32'h8000_0044, 32'h2222_2222, 4'hC, 2'b00, 0);
    chk("t3_read_fourth", 64'(bus.s_arready), 64'd1);
    tick();
    read_tail(32'h8000_0084, 32'hCAFE_F00D, 2'b00, 0);

    // Timeout after 8 WAIT cycles, late pulse ignored
    bus.s_arvalid = 1'b1;
    bus.s_araddr  = 32'h8000_0100;
    tick();
    bus.s_arvalid = 1'b0;
    chk("t4_ren", 64'(bus.m_ren), 64'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_wait_no_rvalid", 64'(bus.s_rvalid), 64'd0);
    end
    tick();
    chk("t4_rvalid", 64'(bus.s_rvalid), 64'd1);
    chk("t4_slverr", 64'(bus.s_rresp), 64'd2);
    chk("t4_rdata_zero", 64'(bus.s_rdata), 64'd0);
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h55AA_55AA;
    bus.m_rresp  = 2'b00;
    tick();
    bus.m_rvalid = 1'b0;
    chk("t4_late_rvalid", 64'(bus.s_rvalid), 64'd1);
    chk("t4_late_rdata", 64'(bus.s_rdata), 64'd0);
    chk("t4_late_rresp", 64'(bus.s_rresp), 64'd2);
    bus.s_rready = 1'b1;
    tick();
    bus.s_rready = 1'b0;
    chk("t4_rvalid_drop", 64'(bus.s_rvalid), 64'd0);
    chk("t4_idle", 64'(bus.s_arready), 64'd1);

    // Async reset while in WR_WAIT
    bus.s_awvalid = 1'b1;
    bus.s_awaddr  = 32'h8000_0020;
    bus.s_wvalid  = 1'b1;
    bus.s_wdata   = 32'hA5A5_A5A5;
    bus.s_wstrb   = 4'hF;
    tick();
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    tick();
    chk("t5_wen", 64'(bus.m_wen), 64'd1);
    tick();
    chk("t5_in_wait", 64'(bus.m_wen), 64'd0);
    rst = 1'b1;
    #1;
    chk("t5_awaddr0", 64'(bus.m_awaddr), 64'd0);
    chk("t5_wdata0", 64'(bus.m_wdata), 64'd0);
    chk("t5_wstrb0", 64'(bus.m_wstrb), 64'd0);
    chk("t5_bvalid0", 64'(bus.s_bvalid), 64'd0);
    chk("t5_araddr0", 64'(bus.m_araddr), 64'd0);
    chk("t5_awready1", 64'(bus.s_awready), 64'd1);
    bus.m_bvalid = 1'b1;
    tick();
    bus.m_bvalid = 1'b0;
    rst = 1'b0;
    tick();
    chk("t5_no_bvalid", 64'(bus.s_bvalid), 64'd0);
    tick();
    chk("t5_no_bvalid2", 64'(bus.s_bvalid), 64'd0);
    chk("t5_no_wen", 64'(bus.m_wen), 64'd0);
    bus.s_arvalid = 1'b1;
    bus.s_araddr  = 32'h8000_0200;
    tick();
    read_tail(32'h8000_0200, 32'h0BAD_F00D, 2'b00, 0);

    // rready held low 5 cycles with m_rdata toggling
    bus.s_arvalid = 1'b1;
    bus.s_araddr  = 32'h8000_0300;
    tick();
    read_tail(32'h8000_0300, 32'h1357_9BDF, 2'b00, 5);
    chk("t6_idle", 64'(bus.s_arready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
